// File: rtl/cart_load_arbiter.sv
// rtl/cart_load_arbiter.sv - cartridge RAM owner arbitrating HPS image download against CPU cart reads
// Downloads always win the single RAM port; the CPU is held until the image settles.

module cart_load_arbiter #(
   parameter int ADDR_W      = 14,
   parameter int HOLD_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [15:0]       ioctl_addr,
   input  logic [7:0]        ioctl_data,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_hold,
   output logic              cart_valid,
   output logic [ADDR_W:0]   cart_size,
   output logic              cart_ovf,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_HOLD, S_READY} state_t;

   localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  hold_cnt, hold_cnt_nx;
   logic              wr_req, wr_in_range, wr_ok, wr_drop;
   logic              load_entry, rd_go;
   logic [ADDR_W:0]   wr_end, size_base, size_nx;
   logic              ovf_nx;
   logic              ack_q, rd_real_q;

   assign wr_req      = ioctl_download & ioctl_wr;
   assign wr_in_range = ({1'b0, ioctl_addr} < (17'd1 << ADDR_W));
   assign wr_ok       = wr_req & wr_in_range;
   assign wr_drop     = wr_req & ~wr_in_range;
   assign wr_end      = {1'b0, ioctl_addr[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};

   // A fresh load starts from zero, but its entry-cycle write must still count.
   assign load_entry = ioctl_download & ((state == S_EMPTY) | (state == S_READY));
   assign size_base  = load_entry ? '0 : cart_size;
   assign size_nx    = (wr_ok && (wr_end > size_base)) ? wr_end : size_base;
   assign ovf_nx     = (load_entry ? 1'b0 : cart_ovf) | wr_drop;

   assign rd_go = cpu_req & (state == S_READY) & ~wr_ok;

   always_comb begin
      state_nx    = state;
      hold_cnt_nx = '0;
      case (state)
         S_EMPTY, S_READY: begin
            if (ioctl_download) state_nx = S_LOAD;
         end
         S_LOAD: begin
            if (!ioctl_download) state_nx = (cart_size != '0) ? S_HOLD : S_EMPTY;
         end
         S_HOLD: begin
            if (ioctl_download) begin
               state_nx = S_LOAD;
            end else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
               state_nx = S_READY;
            end else begin
               hold_cnt_nx = hold_cnt + 1'b1;
            end
         end
         default: state_nx = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_EMPTY;
         hold_cnt  <= '0;
         cart_size <= '0;
         cart_ovf  <= 1'b0;
         ack_q     <= 1'b0;
         rd_real_q <= 1'b0;
      end else begin
         state     <= state_nx;
         hold_cnt  <= hold_cnt_nx;
         cart_size <= size_nx;
         cart_ovf  <= ovf_nx;
         ack_q     <= cpu_req;
         rd_real_q <= rd_go;
      end
   end

   assign cpu_hold   = (state == S_LOAD) | (state == S_HOLD);
   assign cart_valid = (state == S_READY);
   assign cpu_ack    = ack_q;
   assign cpu_rdata  = rd_real_q ? mem_rdata : 8'hFF;

   assign mem_we    = wr_ok;
   assign mem_addr  = wr_ok ? ioctl_addr[ADDR_W-1:0] : cpu_addr;
   assign mem_wdata = ioctl_data;

endmodule

// File: tb/tb_cart_load_arbiter.sv
// tb/tb_cart_load_arbiter.sv - randomized self-checking bench for cart_load_arbiter
// Keeps its own picture of the loaded image, size, overflow and readiness.

module tb_cart_load_arbiter;

   localparam int ADDR_W = 14;
   localparam int HOLD   = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              ioctl_download = 1'b0;
   logic              ioctl_wr = 1'b0;
   logic [15:0]       ioctl_addr = '0;
   logic [7:0]        ioctl_data = '0;
   logic              cpu_req = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic              cpu_ack;
   logic [7:0]        cpu_rdata;
   logic              cpu_hold;
   logic              cart_valid;
   logic [ADDR_W:0]   cart_size;
   logic              cart_ovf;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic [7:0]        mem_rdata = '0;

   logic [7:0] ram [DEPTH];
   logic [7:0] img [DEPTH];
   int         m_size;
   bit         m_ovf;
   bit         m_ready;
   int unsigned wq_addr[$];
   logic [7:0]  wq_data[$];
   int         n_tests = 0;
   int         n_fail = 0;

   cart_load_arbiter #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .cpu_hold(cpu_hold), .cart_valid(cart_valid), .cart_size(cart_size), .cart_ovf(cart_ovf),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives download high for at least min_cycles, draining the write queue with random gaps
   task automatic load_bytes(input bit fresh, input int min_cycles);
      bit          w, acc, req_q;
      int unsigned a;
      logic [7:0]  d, exp_q;
      if (fresh) begin
         m_size = 0;
         m_ovf  = 0;
      end
      for (int c = 0; c < 400 && (wq_addr.size() > 0 || c < min_cycles); c++) begin
         w = (wq_addr.size() > 0) && ($urandom_range(3) != 0);
         a = w ? wq_addr.pop_front() : $urandom_range(65535);
         d = w ? wq_data.pop_front() : 8'($urandom);
         ioctl_download = 1'b1;
         ioctl_wr       = w;
         ioctl_addr     = 16'(a);
         ioctl_data     = d;
         cpu_req        = 1'($urandom_range(1));
         cpu_addr       = ADDR_W'($urandom);
         #1;
         acc = w && (a < DEPTH);
         chk("load_we", mem_we, acc);
         if (acc) begin
            chk("load_addr", mem_addr, a);
            chk("load_wdata", mem_wdata, d);
         end
         req_q = cpu_req;
         exp_q = (m_ready && !acc) ? img[cpu_addr] : 8'hFF;
         if (acc) begin
            img[a] = d;
            if (int'(a) + 1 > m_size) m_size = int'(a) + 1;
         end else if (w) begin
            m_ovf = 1;
         end
         tick();
         m_ready = 0;
         chk("load_ack", cpu_ack, req_q);
         if (req_q) chk("load_rdata", cpu_rdata, exp_q);
         chk("load_hold", cpu_hold, 1);
         chk("load_valid", cart_valid, 0);
      end
      cpu_req  = 1'b0;
      ioctl_wr = 1'b0;
      chk("load_size", cart_size, m_size);
      chk("load_ovf", cart_ovf, m_ovf);
   endtask

   // Drops download; abort_after>0 stops watching the hold window early, still inside it
   task automatic end_load(input int abort_after);
      int cnt;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      tick();
      chk("end_size", cart_size, m_size);
      if (m_size == 0) begin
         chk("empty_hold", cpu_hold, 0);
         chk("empty_valid", cart_valid, 0);
         m_ready = 0;
      end else begin
         cnt = 0;
         while (cpu_hold === 1'b1 && cnt < HOLD + 50 && (abort_after == 0 || cnt < abort_after)) begin
            chk("hold_valid", cart_valid, 0);
            cnt++;
            tick();
         end
         if (abort_after == 0) begin
            chk("hold_len", cnt, HOLD);
            chk("ready_valid", cart_valid, 1);
            m_ready = 1;
         end else begin
            chk("hold_mid", cpu_hold, 1);
         end
      end
   endtask

   task automatic read_burst(input int n, input int base, input bit rnd);
      logic [7:0] exp_d;
      for (int i = 0; i < n; i++) begin
         cpu_req  = 1'b1;
         cpu_addr = rnd ? ADDR_W'($urandom) : ADDR_W'(base + i);
         exp_d    = m_ready ? img[cpu_addr] : 8'hFF;
         tick();
         chk("rd_ack", cpu_ack, 1);
         chk("rd_data", cpu_rdata, exp_d);
      end
      cpu_req = 1'b0;
      tick();
      chk("rd_ack_idle", cpu_ack, 0);
   endtask

   initial begin
      logic [7:0] pat [4];
      int         n;
      pat = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = 8'h00;
         img[i] = 8'h00;
      end
      m_size = 0; m_ovf = 0; m_ready = 0;

      repeat (3) tick();
      chk("rst_hold", cpu_hold, 0);
      chk("rst_valid", cart_valid, 0);
      chk("rst_size", cart_size, 0);
      chk("rst_ovf", cart_ovf, 0);
      chk("rst_ack", cpu_ack, 0);
      chk("rst_rdata", cpu_rdata, 8'hFF);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) begin
         wq_addr.push_back(i);
         wq_data.push_back(pat[i]);
      end
      load_bytes(1, 4);
      end_load(0);
      read_burst(1, 2, 0);
      read_burst(4, 0, 0);

      ioctl_download = 1'b0; ioctl_wr = 1'b1; ioctl_addr = 16'd5; ioctl_data = 8'h77;
      #1;
      chk("nodl_we", mem_we, 0);
      tick();
      ioctl_wr = 1'b0;
      chk("nodl_size", cart_size, 4);
      chk("nodl_valid", cart_valid, 1);

      ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 16'd2; ioctl_data = 8'h11;
      cpu_req = 1'b1; cpu_addr = 2;
      #1;
      chk("coll_we", mem_we, 1);
      img[2] = 8'h11; m_size = 3; m_ovf = 0;
      tick();
      m_ready = 0;
      chk("coll_ack", cpu_ack, 1);
      chk("coll_rdata", cpu_rdata, 8'hFF);
      cpu_req = 1'b0; ioctl_wr = 1'b0;
      load_bytes(0, 2);
      end_load(0);
      read_burst(4, 0, 0);

      wq_addr.push_back(32'h4000);
      wq_data.push_back(8'h99);
      load_bytes(1, 3);
      end_load(0);
      chk("ovf_keep", cart_ovf, 1);
      read_burst(3, 0, 1);

      for (int i = 0; i < 10; i++) begin
         wq_addr.push_back(i);
         wq_data.push_back(8'($urandom));
      end
      load_bytes(1, 10);
      reset = 1'b0;
      #1;
      m_size = 0; m_ovf = 0; m_ready = 0;
      chk("mid_rst_size", cart_size, 0);
      chk("mid_rst_hold", cpu_hold, 0);
      tick();
      tick();
      reset = 1'b1;
      wq_addr.push_back(0); wq_data.push_back(8'h21);
      wq_addr.push_back(1); wq_data.push_back(8'h43);
      load_bytes(1, 2);
      end_load(5);
      wq_addr.push_back(6); wq_data.push_back(8'h65);
      load_bytes(0, 3);
      end_load(0);
      chk("rehold_size", cart_size, 7);
      read_burst(8, 0, 0);

      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(12);
         if (it == 0) begin
            wq_addr.push_back(DEPTH - 1);
            wq_data.push_back(8'($urandom));
         end
         for (int k = 0; k < n; k++) begin
            wq_addr.push_back(($urandom_range(9) == 0) ? DEPTH + $urandom_range(1000) : $urandom_range(63));
            wq_data.push_back(8'($urandom));
         end
         load_bytes(1, 1 + $urandom_range(3));
         if (m_size != 0 && $urandom_range(1) == 1) begin
            end_load(1 + $urandom_range(HOLD - 2));
            load_bytes(0, 1 + $urandom_range(2));
         end
         end_load(0);
         read_burst(6, 0, 1);
         read_burst(4, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
